// File: rtl/maze_gen_ctrl_if.sv
// Carver control/data and renderer read port of the maze generation sequencer.
// master = sequencer side, slave = carver/renderer side.
interface maze_gen_ctrl_if #(
  parameter int unsigned MAZE_W = 16,
  parameter int unsigned MAZE_H = 16
);
  localparam int unsigned CELLS = MAZE_W * MAZE_H;
  localparam int unsigned XW    = $clog2(MAZE_W);
  localparam int unsigned YW    = $clog2(MAZE_H);

  // Carver side
  logic             carver_rst_n;
  logic             carver_start;
  logic [2:0]       carver_x_dim;
  logic [2:0]       carver_y_dim;
  logic             carver_finish;
  logic [CELLS-1:0] carver_maze;

  // Renderer read side
  logic             rd_req;
  logic [XW-1:0]    rd_x;
  logic [YW-1:0]    rd_y;
  logic             rd_valid;
  logic             rd_cell;

  modport master (
    output carver_rst_n, carver_start, carver_x_dim, carver_y_dim,
    input  carver_finish, carver_maze,
    input  rd_req, rd_x, rd_y,
    output rd_valid, rd_cell
  );

  modport slave (
    input  carver_rst_n, carver_start, carver_x_dim, carver_y_dim,
    output carver_finish, carver_maze,
    output rd_req, rd_x, rd_y,
    input  rd_valid, rd_cell
  );
endinterface

// File: rtl/maze_gen_ctrl.sv
// Maze generation sequencer: launches and supervises the carver, snapshots the
// finished maze and serves single-cell reads with a one-cycle latency.
module maze_gen_ctrl #(
  parameter int unsigned MAZE_W      = 16,
  parameter int unsigned MAZE_H      = 16,
  parameter int unsigned RST_CYCLES  = 2,
  parameter int unsigned TIMEOUT_CYC = 65535
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             new_maze,
  input  logic [2:0]       x_dim_in,
  input  logic [2:0]       y_dim_in,
  maze_gen_ctrl_if.master  bus,
  output logic             maze_ready,
  output logic             busy,
  output logic             timeout_err,
  output logic [7:0]       gen_count
);
  localparam int unsigned CELLS = MAZE_W * MAZE_H;
  localparam int unsigned IW    = $clog2(CELLS);
  localparam int unsigned RW    = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

  typedef enum logic [2:0] {
    IDLE,
    LAUNCH,
    CARVE,
    CAPTURE,
    READY,
    ERROR
  } state_t;

  state_t           state_q;
  state_t           state_d;
  logic [RW-1:0]    rst_cnt_q;
  logic [15:0]      tmo_cnt_q;
  logic [CELLS-1:0] snapshot_q;
  logic             accept;
  logic             launch_done;
  logic             carve_expired;
  logic             rd_hit;
  logic [IW-1:0]    rd_idx;

  assign launch_done   = (rst_cnt_q == RW'(RST_CYCLES - 1));
  assign carve_expired = (tmo_cnt_q == 16'(TIMEOUT_CYC - 1));
  assign rd_hit        = (state_q == READY) && bus.rd_req;
  assign rd_idx        = IW'(bus.rd_x) + IW'(MAZE_W) * IW'(bus.rd_y);

  always_comb begin
    accept = 1'b0;
    if (new_maze && (state_q == IDLE || state_q == READY || state_q == ERROR))
      accept = 1'b1;
  end

  // State register
  always_ff @(posedge clk) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic; finish takes priority over an expiring timeout
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE, READY, ERROR: if (new_maze) state_d = LAUNCH;
      LAUNCH:             if (launch_done) state_d = CARVE;
      CARVE: begin
        if (bus.carver_finish)  state_d = CAPTURE;
        else if (carve_expired) state_d = ERROR;
      end
      CAPTURE:            state_d = READY;
      default:            state_d = IDLE;
    endcase
  end

  // Control outputs are pure decodes of the registered state
  always_comb begin
    bus.carver_rst_n = 1'b0;
    bus.carver_start = 1'b0;
    busy             = 1'b0;
    maze_ready       = 1'b0;
    unique case (state_q)
      LAUNCH:  busy = 1'b1;
      CARVE, CAPTURE: begin
        bus.carver_rst_n = 1'b1;
        bus.carver_start = 1'b1;
        busy             = 1'b1;
      end
      READY: begin
        bus.carver_rst_n = 1'b1;
        maze_ready       = 1'b1;
      end
      default: ;
    endcase
  end

  // Launch/timeout counters, dimension latch, status and snapshot
  always_ff @(posedge clk) begin
    if (!reset) begin
      rst_cnt_q        <= '0;
      tmo_cnt_q        <= '0;
      bus.carver_x_dim <= '0;
      bus.carver_y_dim <= '0;
      timeout_err      <= 1'b0;
      gen_count        <= '0;
      snapshot_q       <= '0;
    end else begin
      if (state_q == LAUNCH) rst_cnt_q <= rst_cnt_q + RW'(1);
      else                   rst_cnt_q <= '0;

      if (state_q == CARVE) tmo_cnt_q <= tmo_cnt_q + 16'd1;
      else                  tmo_cnt_q <= '0;

      if (accept) begin
        bus.carver_x_dim <= (x_dim_in == 3'd0) ? 3'd1 : x_dim_in;
        bus.carver_y_dim <= (y_dim_in == 3'd0) ? 3'd1 : y_dim_in;
        timeout_err      <= 1'b0;
      end else if (state_q == CARVE && state_d == ERROR) begin
        timeout_err <= 1'b1;
      end

      if (state_q == CAPTURE) begin
        snapshot_q <= bus.carver_maze;
        gen_count  <= gen_count + 8'd1;
      end
    end
  end

  // Read port: one request per cycle, served only while READY
  always_ff @(posedge clk) begin
    if (!reset) begin
      bus.rd_valid <= 1'b0;
      bus.rd_cell  <= 1'b0;
    end else begin
      bus.rd_valid <= rd_hit;
      if (rd_hit) bus.rd_cell <= snapshot_q[rd_idx];
    end
  end

  a_start_implies_out_of_reset: assert property (
    @(posedge clk) disable iff (!reset) bus.carver_start |-> bus.carver_rst_n);

  a_timeout_only_in_error: assert property (
    @(posedge clk) disable iff (!reset) timeout_err |-> (state_q == ERROR));

endmodule
